// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp
//   Parametrised multi-port integer register file with two write ports
//   (ALU writeback on port 0, load writeback on port 1), NRD combinational
//   read ports, optional same-cycle write->read forwarding, an optional
//   hardwired-zero register 0, and a per-register busy scoreboard that
//   tracks registers waiting on a multi-cycle (load) result.
//
// Parameters
//   XLEN      data width of each register
//   NREGS     number of architectural registers (power of 2, >= 2)
//   AW        address width, equal to $clog2(NREGS)
//   NRD       number of read ports (1..4)
//   BYPASS    1: forward same-cycle write data to reads, 0: stored value only
//   ZERO_REG  1: register 0 reads 0, ignores writes and is never busy
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset (clears registers and busy)
//   write_enable0  write port 0 enable (ALU writeback)
//   rd0            write port 0 address
//   write_data0    write port 0 data
//   write_enable1  write port 1 enable (load writeback, wins on conflict)
//   rd1            write port 1 address
//   write_data1    write port 1 data
//   rs             packed read addresses, port i = rs[i*AW +: AW]
//   read_data      packed read data, port i = read_data[i*XLEN +: XLEN]
//   busy_set       mark register busy_idx as pending
//   busy_idx       register to mark pending
//   busy           registered busy vector, bit n = register n
//   rs_busy        read port i addresses a register that is still pending
// ---------------------------------------------------------------------------
module reg_file_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                write_enable0,
  input  logic [AW-1:0]       rd0,
  input  logic [XLEN-1:0]     write_data0,
  input  logic                write_enable1,
  input  logic [AW-1:0]       rd1,
  input  logic [XLEN-1:0]     write_data1,
  input  logic [NRD*AW-1:0]   rs,
  output logic [NRD*XLEN-1:0] read_data,
  input  logic                busy_set,
  input  logic [AW-1:0]       busy_idx,
  output logic [NREGS-1:0]    busy,
  output logic [NRD-1:0]      rs_busy
);

  localparam bit USE_BYPASS = (BYPASS != 0);
  localparam bit USE_ZERO   = (ZERO_REG != 0);

  // Register storage and scoreboard state.
  logic [XLEN-1:0]  regs_reg  [NREGS];
  logic [XLEN-1:0]  regs_next [NREGS];
  logic [NREGS-1:0] busy_reg;
  logic [NREGS-1:0] busy_next;

  // Effective write / busy-set strobes. A write to register 0 with the
  // hardwired-zero option is dropped here so that neither storage nor the
  // forwarding path nor the busy clear ever sees it. Reset masks everything
  // so no forwarding or busy-clear happens in the reset cycle.
  logic wr_en0_eff;
  logic wr_en1_eff;
  logic busy_set_eff;

  assign wr_en0_eff   = write_enable0 & ~rst & ~(USE_ZERO & (rd0 == '0));
  assign wr_en1_eff   = write_enable1 & ~rst & ~(USE_ZERO & (rd1 == '0));
  assign busy_set_eff = busy_set & ~rst & ~(USE_ZERO & (busy_idx == '0));

  // -------------------------------------------------------------------------
  // Per-register next-state
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      logic hit0;
      logic hit1;
      logic bset;

      assign hit0 = wr_en0_eff & (rd0 == AW'(gi));
      assign hit1 = wr_en1_eff & (rd1 == AW'(gi));
      assign bset = busy_set_eff & (busy_idx == AW'(gi));

      if (USE_ZERO && gi == 0) begin : g_zero
        // Hardwired zero: never written, never pending.
        assign regs_next[gi] = '0;
        assign busy_next[gi] = 1'b0;
      end else begin : g_normal
        // Load port wins when both ports target this register.
        always_comb begin
          regs_next[gi] = regs_reg[gi];
          if (hit1) begin
            regs_next[gi] = write_data1;
          end else if (hit0) begin
            regs_next[gi] = write_data0;
          end
        end

        // A committing write clears pending, a same-cycle set overrides it.
        always_comb begin
          busy_next[gi] = busy_reg[gi];
          if (hit0 | hit1) begin
            busy_next[gi] = 1'b0;
          end
          if (bset) begin
            busy_next[gi] = 1'b1;
          end
        end
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NREGS; n++) begin
        regs_reg[n] <= '0;
      end
      busy_reg <= '0;
    end else begin
      for (int n = 0; n < NREGS; n++) begin
        regs_reg[n] <= regs_next[n];
      end
      busy_reg <= busy_next;
    end
  end

  assign busy = busy_reg;

  // -------------------------------------------------------------------------
  // Read ports
  // -------------------------------------------------------------------------
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]   addr;
      logic            fwd0;
      logic            fwd1;
      logic [XLEN-1:0] data;

      assign addr = rs[gi*AW +: AW];
      assign fwd0 = USE_BYPASS & wr_en0_eff & (rd0 == addr);
      assign fwd1 = USE_BYPASS & wr_en1_eff & (rd1 == addr);

      always_comb begin
        data = regs_reg[addr];
        if (fwd1) begin
          data = write_data1;
        end else if (fwd0) begin
          data = write_data0;
        end
      end

      assign read_data[gi*XLEN +: XLEN] = data;

      // A result being forwarded this cycle already satisfies the reader.
      assign rs_busy[gi] = busy_reg[addr] & ~(fwd0 | fwd1);
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_mp.sv
// ---------------------------------------------------------------------------
// tb_reg_file_mp
//   Directed bench for reg_file_mp. Two instances share the same stimulus:
//   dut_a uses the default configuration (BYPASS=1, ZERO_REG=1) and dut_b
//   uses BYPASS=0, ZERO_REG=0 so that the stored-value read path and an
//   ordinary register 0 are exercised alongside the forwarding path.
// ---------------------------------------------------------------------------
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        we0;
  logic [4:0]  rd0;
  logic [31:0] wd0;
  logic        we1;
  logic [4:0]  rd1;
  logic [31:0] wd1;
  logic [4:0]  rs0_t;
  logic [4:0]  rs1_t;
  logic        busy_set;
  logic [4:0]  busy_idx;
  logic [9:0]  rs;

  logic [63:0] read_data_a;
  logic [63:0] read_data_b;
  logic [31:0] busy_a;
  logic [31:0] busy_b;
  logic [1:0]  rs_busy_a;
  logic [1:0]  rs_busy_b;

  logic [31:0] rd_a0;
  logic [31:0] rd_a1;
  logic [31:0] rd_b0;
  logic [31:0] rd_b1;

  int n_vec = 0;
  int n_err = 0;

  assign rs    = {rs1_t, rs0_t};
  assign rd_a0 = read_data_a[31:0];
  assign rd_a1 = read_data_a[63:32];
  assign rd_b0 = read_data_b[31:0];
  assign rd_b1 = read_data_b[63:32];

  always #5 clk = ~clk;

  reg_file_mp #(
    .XLEN(32), .NREGS(32), .AW(5), .NRD(2), .BYPASS(1), .ZERO_REG(1)
  ) dut_a (
    .clk(clk), .rst(rst),
    .write_enable0(we0), .rd0(rd0), .write_data0(wd0),
    .write_enable1(we1), .rd1(rd1), .write_data1(wd1),
    .rs(rs), .read_data(read_data_a),
    .busy_set(busy_set), .busy_idx(busy_idx),
    .busy(busy_a), .rs_busy(rs_busy_a)
  );

  reg_file_mp #(
    .XLEN(32), .NREGS(32), .AW(5), .NRD(2), .BYPASS(0), .ZERO_REG(0)
  ) dut_b (
    .clk(clk), .rst(rst),
    .write_enable0(we0), .rd0(rd0), .write_data0(wd0),
    .write_enable1(we1), .rd1(rd1), .write_data1(wd1),
    .rs(rs), .read_data(read_data_b),
    .busy_set(busy_set), .busy_idx(busy_idx),
    .busy(busy_b), .rs_busy(rs_busy_b)
  );

  task automatic idle();
    we0 = 1'b0; rd0 = '0; wd0 = '0;
    we1 = 1'b0; rd1 = '0; wd1 = '0;
    busy_set = 1'b0; busy_idx = '0;
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    rs0_t = 5'd5; rs1_t = 5'd10;
    tick();
    rst = 1'b0;
    #1;
    n_vec++; if (read_data_a !== 64'h0) begin n_err++; $display("FAIL reset_read_a: got %h want %h", read_data_a, 64'h0); end
    n_vec++; if (read_data_b !== 64'h0) begin n_err++; $display("FAIL reset_read_b: got %h want %h", read_data_b, 64'h0); end
    n_vec++; if (busy_a !== 32'h0) begin n_err++; $display("FAIL reset_busy_a: got %h want %h", busy_a, 32'h0); end
    n_vec++; if (busy_b !== 32'h0) begin n_err++; $display("FAIL reset_busy_b: got %h want %h", busy_b, 32'h0); end
    n_vec++; if (rs_busy_a !== 2'b00 || rs_busy_b !== 2'b00) begin n_err++; $display("FAIL reset_rs_busy: got %b/%b want 00/00", rs_busy_a, rs_busy_b); end
    $display("reset: read_data_a=%h busy_a=%h", read_data_a, busy_a);
  endtask

  task automatic test_bypass_write();
    we0 = 1'b1; rd0 = 5'd5; wd0 = 32'hABCD1234;
    rs0_t = 5'd5; rs1_t = 5'd10;
    #1;
    n_vec++; if (rd_a0 !== 32'hABCD1234) begin n_err++; $display("FAIL bypass_same_cycle_a: got %h want %h", rd_a0, 32'hABCD1234); end
    n_vec++; if (rd_b0 !== 32'h0) begin n_err++; $display("FAIL nobypass_same_cycle_b: got %h want %h", rd_b0, 32'h0); end
    n_vec++; if (rd_a1 !== 32'h0) begin n_err++; $display("FAIL bypass_other_port_a: got %h want %h", rd_a1, 32'h0); end
    tick();
    idle();
    #1;
    n_vec++; if (rd_a0 !== 32'hABCD1234) begin n_err++; $display("FAIL write_after_edge_a: got %h want %h", rd_a0, 32'hABCD1234); end
    n_vec++; if (rd_b0 !== 32'hABCD1234) begin n_err++; $display("FAIL write_after_edge_b: got %h want %h", rd_b0, 32'hABCD1234); end
    $display("write r5: a=%h b=%h", rd_a0, rd_b0);
  endtask

  task automatic test_write_conflict();
    we0 = 1'b1; rd0 = 5'd10; wd0 = 32'h11111111;
    we1 = 1'b1; rd1 = 5'd10; wd1 = 32'h12345678;
    rs1_t = 5'd10;
    #1;
    n_vec++; if (rd_a1 !== 32'h12345678) begin n_err++; $display("FAIL conflict_bypass_a: got %h want %h", rd_a1, 32'h12345678); end
    tick();
    idle();
    #1;
    n_vec++; if (rd_a1 !== 32'h12345678) begin n_err++; $display("FAIL conflict_stored_a: got %h want %h", rd_a1, 32'h12345678); end
    n_vec++; if (rd_b1 !== 32'h12345678) begin n_err++; $display("FAIL conflict_stored_b: got %h want %h", rd_b1, 32'h12345678); end
    $display("conflict r10: a=%h b=%h", rd_a1, rd_b1);
  endtask

  task automatic test_zero_reg();
    we0 = 1'b1; rd0 = 5'd0; wd0 = 32'hFFFFFFFF;
    busy_set = 1'b1; busy_idx = 5'd0;
    rs0_t = 5'd0;
    #1;
    n_vec++; if (rd_a0 !== 32'h0) begin n_err++; $display("FAIL zero_no_bypass_a: got %h want %h", rd_a0, 32'h0); end
    tick();
    idle();
    #1;
    n_vec++; if (rd_a0 !== 32'h0) begin n_err++; $display("FAIL zero_read_a: got %h want %h", rd_a0, 32'h0); end
    n_vec++; if (busy_a !== 32'h0) begin n_err++; $display("FAIL zero_busy_a: got %h want %h", busy_a, 32'h0); end
    n_vec++; if (rd_b0 !== 32'hFFFFFFFF) begin n_err++; $display("FAIL r0_plain_read_b: got %h want %h", rd_b0, 32'hFFFFFFFF); end
    n_vec++; if (busy_b !== 32'h1) begin n_err++; $display("FAIL r0_plain_busy_b: got %h want %h", busy_b, 32'h1); end
    // Load writeback of 0 into r0: clears dut_b's pending bit and data.
    we1 = 1'b1; rd1 = 5'd0; wd1 = 32'h0;
    tick();
    idle();
    #1;
    n_vec++; if (busy_b !== 32'h0 || rd_b0 !== 32'h0) begin n_err++; $display("FAIL r0_clear_b: got busy=%h data=%h want 0/0", busy_b, rd_b0); end
    $display("zero reg: a=%h busy_a=%h b=%h busy_b=%h", rd_a0, busy_a, rd_b0, busy_b);
  endtask

  task automatic test_busy();
    busy_set = 1'b1; busy_idx = 5'd7;
    rs0_t = 5'd7; rs1_t = 5'd10;
    tick();
    idle();
    #1;
    n_vec++; if (busy_a !== 32'h80) begin n_err++; $display("FAIL busy_set_a: got %h want %h", busy_a, 32'h80); end
    n_vec++; if (busy_b !== 32'h80) begin n_err++; $display("FAIL busy_set_b: got %h want %h", busy_b, 32'h80); end
    n_vec++; if (rs_busy_a !== 2'b01) begin n_err++; $display("FAIL rs_busy_pending_a: got %b want %b", rs_busy_a, 2'b01); end
    // Load result for r7 arrives.
    we1 = 1'b1; rd1 = 5'd7; wd1 = 32'h55;
    #1;
    n_vec++; if (rs_busy_a !== 2'b00) begin n_err++; $display("FAIL rs_busy_bypass_a: got %b want %b", rs_busy_a, 2'b00); end
    n_vec++; if (rs_busy_b !== 2'b01) begin n_err++; $display("FAIL rs_busy_nobypass_b: got %b want %b", rs_busy_b, 2'b01); end
    n_vec++; if (rd_a0 !== 32'h55) begin n_err++; $display("FAIL load_bypass_a: got %h want %h", rd_a0, 32'h55); end
    tick();
    idle();
    #1;
    n_vec++; if (busy_a !== 32'h0 || busy_b !== 32'h0) begin n_err++; $display("FAIL busy_clear: got %h/%h want 0/0", busy_a, busy_b); end
    n_vec++; if (rd_b0 !== 32'h55) begin n_err++; $display("FAIL load_stored_b: got %h want %h", rd_b0, 32'h55); end
    // Same-cycle set and write on r7: set wins.
    we0 = 1'b1; rd0 = 5'd7; wd0 = 32'h66;
    busy_set = 1'b1; busy_idx = 5'd7;
    tick();
    idle();
    #1;
    n_vec++; if (busy_a !== 32'h80 || busy_b !== 32'h80) begin n_err++; $display("FAIL set_wins: got %h/%h want 80/80", busy_a, busy_b); end
    n_vec++; if (rd_a0 !== 32'h66 || rd_b0 !== 32'h66) begin n_err++; $display("FAIL set_wins_data: got %h/%h want 66/66", rd_a0, rd_b0); end
    $display("busy: busy_a=%h rs_busy_a=%b", busy_a, rs_busy_a);
  endtask

  task automatic test_back_to_back();
    logic [31:0] prev;
    rs0_t = 5'd3; rs1_t = 5'd3;
    prev = 32'h0;
    for (int k = 1; k <= 3; k++) begin
      we0 = 1'b1; rd0 = 5'd3; wd0 = 32'h101 * k;
      #1;
      n_vec++; if (rd_a0 !== 32'h101 * k || rd_a1 !== 32'h101 * k) begin n_err++; $display("FAIL b2b_bypass_a[%0d]: got %h/%h want %h", k, rd_a0, rd_a1, 32'h101 * k); end
      n_vec++; if (rd_b0 !== prev || rd_b1 !== prev) begin n_err++; $display("FAIL b2b_stored_b[%0d]: got %h/%h want %h", k, rd_b0, rd_b1, prev); end
      $display("b2b k=%0d: a=%h b=%h", k, rd_a0, rd_b0);
      prev = 32'h101 * k;
      tick();
    end
    idle();
    #1;
    n_vec++; if (rd_b0 !== 32'h303) begin n_err++; $display("FAIL b2b_final_b: got %h want %h", rd_b0, 32'h303); end
  endtask

  task automatic test_reset_flush();
    busy_set = 1'b1; busy_idx = 5'd3;
    tick();
    idle();
    #1;
    n_vec++; if (busy_a !== 32'h88) begin n_err++; $display("FAIL flush_pre_busy_a: got %h want %h", busy_a, 32'h88); end
    // Reset cycle with a write, busy_set and a read of the written register.
    rst = 1'b1;
    we0 = 1'b1; rd0 = 5'd5; wd0 = 32'hDEADBEEF;
    busy_set = 1'b1; busy_idx = 5'd4;
    rs0_t = 5'd5; rs1_t = 5'd10;
    #1;
    n_vec++; if (rd_a0 !== 32'hABCD1234) begin n_err++; $display("FAIL rst_bypass_suppressed_a: got %h want %h", rd_a0, 32'hABCD1234); end
    tick();
    rst = 1'b0;
    idle();
    #1;
    n_vec++; if (read_data_a !== 64'h0 || read_data_b !== 64'h0) begin n_err++; $display("FAIL flush_read: got %h/%h want 0/0", read_data_a, read_data_b); end
    n_vec++; if (busy_a !== 32'h0 || busy_b !== 32'h0) begin n_err++; $display("FAIL flush_busy: got %h/%h want 0/0", busy_a, busy_b); end
    rs0_t = 5'd3; rs1_t = 5'd7;
    #1;
    n_vec++; if (read_data_a !== 64'h0 || read_data_b !== 64'h0) begin n_err++; $display("FAIL flush_read_3_7: got %h/%h want 0/0", read_data_a, read_data_b); end
    n_vec++; if (rs_busy_a !== 2'b00 || rs_busy_b !== 2'b00) begin n_err++; $display("FAIL flush_rs_busy: got %b/%b want 00/00", rs_busy_a, rs_busy_b); end
    $display("reset flush: a=%h busy_a=%h", read_data_a, busy_a);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    rs0_t = '0; rs1_t = '0;
    test_reset();
    test_bypass_write();
    test_write_conflict();
    test_zero_reg();
    test_busy();
    test_back_to_back();
    test_reset_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
